// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back path: widths, the buffered
// write-back entry and the ROB-relative age helper.
package rf_pkg;

  localparam int ADDR = 5;
  localparam int TAG  = 7;

  typedef struct packed {
    logic [ADDR-1:0] rd;
    logic [TAG-1:0]  tag;
    logic [31:0]     data;
  } wb_entry_t;

  // Distance from the ROB head; the TAG-bit subtraction wraps with the ROB.
  function automatic logic [TAG-1:0] rob_age(input logic [TAG-1:0] tag,
                                             input logic [TAG-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// DEPTH-entry write-back lane buffer; head visible the edge after push.
// full holds off the producer; pop and push in one cycle keep occupancy, no bypass.
module wb_lane_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-lane write-back arbiter onto the single register-file write port.
// Accept-to-write is 2 edges; rdyN is low only while lane N's FIFO is full.
module rf_wb_arbiter #(
  parameter int ADDR  = 5,
  parameter int TAG   = 7,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            v0,
  input  logic            v1,
  input  logic [ADDR-1:0] rd0,
  input  logic [ADDR-1:0] rd1,
  input  logic [TAG-1:0]  tag0,
  input  logic [TAG-1:0]  tag1,
  input  logic [31:0]     data0,
  input  logic [31:0]     data1,
  output logic            rdy0,
  output logic            rdy1,
  input  logic [TAG-1:0]  rob_head,
  input  logic            flush,
  output logic            we_w,
  output logic [ADDR-1:0] wa_w,
  output logic [31:0]     wd,
  output logic [TAG-1:0]  wtag,
  output logic            busy
);

  import rf_pkg::*;

  wb_entry_t       in0, in1, head0, head1, gnt_dat;
  logic            full0, full1, empty0, empty1;
  logic            push0, push1, pop0, pop1;
  logic            gnt_vld, gnt_lane;
  logic            rr_q, rr_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] wa_q, wa_d;
  logic [31:0]     wd_q, wd_d;
  logic [TAG-1:0]  wtag_q, wtag_d;

  assign in0 = '{rd: rd0, tag: tag0, data: data0};
  assign in1 = '{rd: rd1, tag: tag1, data: data1};

  assign rdy0 = !full0;
  assign rdy1 = !full1;
  assign busy = !empty0 || !empty1;

  // Writes to x0 are accepted for flow control but never stored.
  assign push0 = v0 && !flush && (rd0 != '0);
  assign push1 = v1 && !flush && (rd1 != '0);

  wb_lane_fifo #(.DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .push(push0), .push_dat(in0), .pop(pop0),
    .full(full0), .empty(empty0), .head(head0)
  );

  wb_lane_fifo #(.DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .push(push1), .push_dat(in1), .pop(pop1),
    .full(full1), .empty(empty1), .head(head1)
  );

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = 1'b0;
    rr_d     = rr_q;
    if (flush) begin
      rr_d = 1'b0;
    end else if (!empty0 && !empty1) begin
      gnt_vld = 1'b1;
      // Same destination: oldest first so the youngest value lands last.
      if (head0.rd == head1.rd) begin
        gnt_lane = rob_age(head1.tag, rob_head) < rob_age(head0.tag, rob_head);
      end else begin
        gnt_lane = rr_q;
        rr_d     = ~rr_q;
      end
    end else if (!empty0) begin
      gnt_vld = 1'b1;
    end else if (!empty1) begin
      gnt_vld  = 1'b1;
      gnt_lane = 1'b1;
    end
  end

  assign pop0    = gnt_vld && !gnt_lane;
  assign pop1    = gnt_vld && gnt_lane;
  assign gnt_dat = gnt_lane ? head1 : head0;

  always_comb begin
    we_d   = gnt_vld;
    wa_d   = wa_q;
    wd_d   = wd_q;
    wtag_d = wtag_q;
    if (gnt_vld) begin
      wa_d   = gnt_dat.rd;
      wd_d   = gnt_dat.data;
      wtag_d = gnt_dat.tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q   <= 1'b0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      wtag_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      wtag_q <= wtag_d;
    end
  end

  assign we_w = we_q;
  assign wa_w = wa_q;
  assign wd   = wd_q;
  assign wtag = wtag_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the tagged register file. It shares the register file's single write-back port (WE_W, WA_W, WD) between two write-back lanes: lane 0 is the ALU/branch lane and lane 1 is the load/store lane. Each lane is buffered in a 2-entry FIFO with valid/ready. Writes to the same destination register are ordered oldest-first by ROB age, so the architecturally correct value lands last.

## Interface
Parameters:
- ADDR, 5: register address width (32 registers).
- TAG, 7: ROB tag width; ROB has 2**TAG entries.
- DEPTH, 2: per-lane FIFO depth (power of two).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- v0, v1  in  1  lane write-back request valid.
- rd0, rd1  in  ADDR  destination register.
- tag0, tag1  in  TAG  ROB tag of the producing instruction.
- data0, data1  in  32  result data.
- rdy0, rdy1  out  1  lane can accept; high iff that lane's FIFO is not full.
- rob_head  in  TAG  current ROB head pointer, used for age comparison.
- flush  in  1  pipeline flush; synchronously discards all buffered entries.
- we_w  out  1  register file write-back enable (registered).
- wa_w  out  ADDR  write address (registered).
- wd  out  32  write data (registered).
- wtag  out  TAG  tag of the issued write (registered; debug/ROB broadcast).
- busy  out  1  high while either FIFO is non-empty (combinational from occupancy).

## Operation
- Accept: on a clock edge with vN && rdyN && !flush, the lane captures {rd, tag, data}.
  - An entry with rd == 0 is accepted and then discarded; it is never stored.
- rdyN depends only on current occupancy (full = DEPTH entries).
  - A pop in the same cycle does not raise rdy; there is no bypass.
- Grant, evaluated each cycle on the FIFO heads:
  - Neither lane holds an entry: no grant; we_w = 0 next cycle.
  - Exactly one lane holds an entry: that lane is granted.
  - Both hold entries with the same rd: the older one is granted.
    - Age = (tag − rob_head) mod 2**TAG; smaller age is older; equal age grants lane 0.
    - The round-robin pointer is not updated.
  - Both hold entries with different rd: the round-robin pointer picks the lane. After the grant the pointer moves to the other lane.
- Granted entry is popped at the clock edge. On that edge we_w/wa_w/wd/wtag load the entry with we_w = 1; otherwise we_w loads 0 and the other outputs hold their values.
- At most one write per cycle.
- Flush (synchronous, highest priority):
  - Both FIFOs are emptied; same-cycle requests are ignored.
  - No grant is made; we_w loads 0.
  - The round-robin pointer resets to lane 0.
  - rdy rises the next cycle.
- Reset (asynchronous, rstn low):
  - FIFOs empty, pointer = lane 0.
  - we_w = 0, wa_w = 0, wd = 0, wtag = 0.
  - rdy0 = rdy1 = 1 and busy = 0 while reset is held and after release.
  - Reset mid-burst drops all buffered entries, with no partial write.

## Timing
- Latency: entry accepted at edge k appears as FIFO head after k.
  - Its earliest grant is in the cycle between edges k and k+1.
  - we_w is high in the cycle following edge k+1 (2 edges after acceptance).
- Throughput: 1 write/cycle sustained. One busy lane streams at 1/cycle; two busy lanes alternate, except during same-rd age ordering.
- FIFO pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Age subtraction is TAG bits and wraps naturally. Tags straddling the ROB wrap (e.g. head = 126, tags 127 and 1) must order 127 before 1.

## Structure
- Shared package rf_pkg:
  - ADDR and TAG constants.
  - wb_entry_t = {rd, tag, data}.
  - function rob_age(tag, head) returning the TAG-bit age.
- One sub-module: wb_lane_fifo (DEPTH-entry synchronous FIFO with async reset and flush, push/pop/full/empty/head), instantiated twice.
- Grant logic, round-robin pointer and output register live in the top module.

## Test plan
- Reset mid-burst: fill both FIFOs, pull rstn low → we_w = 0, busy = 0, rdy0 = rdy1 = 1 immediately; no write after release.
- Single lane: lane 0 sends rd = 3 on 3 consecutive cycles, data 0x11/0x22/0x33 → we_w high on 3 consecutive cycles starting 2 edges after the first accept, wa_w = 3, wd in order.
- Round robin: both lanes continuously valid with rd 4 and 5 → grants alternate 0,1,0,1. rdyN drops when its FIFO reaches 2 entries and stays low until a pop.
- Same-rd age ordering across wrap: rob_head = 126, lane 0 {rd 7, tag 1}, lane 1 {rd 7, tag 127} on the same cycle → lane 1 written first, lane 0 second; final wd is lane 0's data.
- x0 and flush: lane 1 sends rd = 0 → accepted, no we_w. Then both FIFOs loaded and flush asserted → no we_w the next cycle, busy = 0, pointer back to lane 0.
